// File: rtl/proc_run_ctrl.sv
// Run controller for the single-cycle core: reset sequencing, clock-enable gating,
// cycle counting, stop on limit or halt. Optional single-step support via STEP_MODE_EN.
module proc_run_ctrl #(
    parameter int CNT_W    = 16,
    parameter int HOLD_CYC = 2,
    parameter int SYNC_STG = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             halt,
    input  logic [CNT_W-1:0] limit,
    input  logic             step_mode,
    input  logic             step,
    output logic             core_rst,
    output logic             core_ce,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             done,
    output logic [1:0]       state
);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {S_HOLD = 2'd0, S_IDLE = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} st_t;

    st_t                 st;
    logic [SYNC_STG-1:0] rst_sync;
    logic [HW-1:0]       hold_cnt;
    logic [CNT_W-1:0]    lim_q;
    logic [CNT_W:0]      cnt_inc;
    logic [CNT_W-1:0]    cnt_sat;
    logic                hit_lim;
    logic                run_ce;
    logic                entry_ce;

    // Async assert, sync deassert of the internal release.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rst_sync <= '0;
        else      rst_sync <= {rst_sync[SYNC_STG-2:0], 1'b1};
    end

`ifdef STEP_MODE_EN
    logic step_q;

    // Tracks step in every state so a level held across entry to RUN never fires.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) step_q <= 1'b0;
        else      step_q <= step;
    end

    always_comb begin
        run_ce   = step_mode ? (step & ~step_q) : 1'b1;
        entry_ce = ~step_mode;
    end
`else
    logic unused_step;
    assign unused_step = step ^ step_mode;

    always_comb begin
        run_ce   = 1'b1;
        entry_ce = 1'b1;
    end
`endif

    always_comb begin
        cnt_inc = {1'b0, cycle_cnt} + {{CNT_W{1'b0}}, 1'b1};
        hit_lim = (lim_q != '0) && (cnt_inc == {1'b0, lim_q});
        cnt_sat = (&cycle_cnt) ? cycle_cnt : cnt_inc[CNT_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st        <= S_HOLD;
            core_rst  <= 1'b1;
            core_ce   <= 1'b0;
            cycle_cnt <= '0;
            done      <= 1'b0;
            hold_cnt  <= '0;
            lim_q     <= '0;
        end else begin
            case (st)
                S_HOLD: begin
                    if (rst_sync[SYNC_STG-1]) begin
                        if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                            core_rst <= 1'b0;
                            st       <= S_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    if (start) begin
                        st        <= S_RUN;
                        lim_q     <= limit;
                        cycle_cnt <= '0;
                        done      <= 1'b0;
                        core_ce   <= entry_ce;
                    end
                end
                S_RUN: begin
                    if (core_ce) begin
                        // The terminating cycle is still counted.
                        cycle_cnt <= cnt_sat;
                        if (hit_lim || halt) begin
                            core_ce <= 1'b0;
                            done    <= 1'b1;
                            st      <= S_DONE;
                        end else begin
                            core_ce <= run_ce;
                        end
                    end else begin
                        core_ce <= run_ce;
                    end
                end
                default: st <= S_HOLD;
            endcase
        end
    end

    assign state = st;
endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: expected run results are queued at start,
// a negedge monitor pops and compares whenever done rises.
module tb_proc_run_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0, halt = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic [15:0] limit = '0;
    logic        core_rst, core_ce, done;
    logic [15:0] cycle_cnt;
    logic [1:0]  state;

    logic        start2 = 1'b0, halt2 = 1'b0;
    logic [3:0]  limit2 = '0;
    logic        core_rst2, core_ce2, done2;
    logic [3:0]  cnt2;
    logic [1:0]  state2;

    typedef struct {int cnt; int ce;} exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int ce_run = 0;
    logic       prev_done = 1'b0;
    logic [1:0] prev_state = 2'd0;

    always #5 CLK = ~CLK;

    proc_run_ctrl #(.CNT_W(16), .HOLD_CYC(2), .SYNC_STG(2)) dut (
        .CLK(CLK), .RST(RST), .start(start), .halt(halt), .limit(limit),
        .step_mode(step_mode), .step(step), .core_rst(core_rst), .core_ce(core_ce),
        .cycle_cnt(cycle_cnt), .done(done), .state(state));

    proc_run_ctrl #(.CNT_W(4), .HOLD_CYC(2), .SYNC_STG(2)) dut_sat (
        .CLK(CLK), .RST(RST), .start(start2), .halt(halt2), .limit(limit2),
        .step_mode(step_mode), .step(step), .core_rst(core_rst2), .core_ce(core_ce2),
        .cycle_cnt(cnt2), .done(done2), .state(state2));

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && !done; i++) tick(1);
        chk("done_within_bound", int'(done), 1);
        tick(1);
    endtask

    // Monitor: per-run enabled-cycle tally, reset gating invariant, scoreboard pop.
    always @(negedge CLK) begin
        if (core_rst)  chk("rst_gates_ce", int'(core_ce), 0);
        if (core_rst2) chk("rst_gates_ce_sat", int'(core_ce2), 0);
        if (state == 2'd2 && prev_state != 2'd2) ce_run = int'(core_ce);
        else if (core_ce) ce_run++;
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done with cnt %0d, expected no run end", cycle_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("run_cycle_cnt", int'(cycle_cnt), e.cnt);
                chk("run_ce_cycles", ce_run, e.ce);
                chk("run_state_done", int'(state), 3);
            end
        end
        prev_done  = done;
        prev_state = state;
    end

    initial begin
        // Reset and release sequence
        tick(3);
        chk("rst_core_rst", int'(core_rst), 1);
        chk("rst_core_ce", int'(core_ce), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_cnt", int'(cycle_cnt), 0);
        chk("rst_done", int'(done), 0);
        RST = 1'b1;
        tick(3);
        chk("hold_edge3_core_rst", int'(core_rst), 1);
        chk("hold_edge3_state", int'(state), 0);
        tick(1);
        chk("rel_edge4_core_rst", int'(core_rst), 0);
        chk("rel_edge4_state", int'(state), 1);
        chk("rel_edge4_core_ce", int'(core_ce), 0);

        // Halt ignored in IDLE
        halt = 1'b1; tick(2); halt = 1'b0;
        chk("idle_halt_state", int'(state), 1);
        chk("idle_halt_ce", int'(core_ce), 0);

        // limit=40, limit change mid-run ignored
        limit = 16'd40;
        sb.push_back('{40, 40});
        start = 1'b1; tick(1); start = 1'b0;
        limit = 16'd7;
        wait_done();
        chk("lim40_state", int'(state), 3);
        chk("lim40_cnt", int'(cycle_cnt), 40);

        // Halt ignored in DONE
        halt = 1'b1; tick(2); halt = 1'b0;
        chk("done_halt_state", int'(state), 3);
        chk("done_halt_cnt", int'(cycle_cnt), 40);

        // Restart from DONE with limit=5, core_rst not re-asserted
        limit = 16'd5;
        sb.push_back('{5, 5});
        start = 1'b1; tick(1); start = 1'b0;
        chk("restart_core_rst", int'(core_rst), 0);
        chk("restart_cnt_clr", int'(cycle_cnt), 0);
        chk("restart_done_clr", int'(done), 0);
        wait_done();
        chk("lim5_core_rst", int'(core_rst), 0);

        // Unlimited run stopped by halt after 10 enabled cycles
        limit = 16'd0;
        sb.push_back('{11, 11});
        start = 1'b1; tick(1); start = 1'b0;
        tick(10);
        chk("halt_pre_cnt", int'(cycle_cnt), 10);
        halt = 1'b1; tick(1); halt = 1'b0;
        chk("halt_done", int'(done), 1);
        chk("halt_cnt", int'(cycle_cnt), 11);
        tick(1);

`ifdef STEP_MODE_EN
        // Single-step: held level at entry does not fire; one pulse per rising edge
        step_mode = 1'b1; step = 1'b1; limit = 16'd3;
        sb.push_back('{3, 3});
        start = 1'b1; tick(1); start = 1'b0;
        tick(3);
        chk("step_held_ce", int'(core_ce), 0);
        chk("step_held_cnt", int'(cycle_cnt), 0);
        step = 1'b0; tick(1);
        step = 1'b1; tick(1);
        chk("step1_ce_on", int'(core_ce), 1);
        tick(1);
        chk("step1_ce_off", int'(core_ce), 0);
        chk("step1_cnt", int'(cycle_cnt), 1);
        tick(3);
        chk("step_hold_cnt", int'(cycle_cnt), 1);
        step = 1'b0; tick(1); step = 1'b1; tick(2);
        chk("step2_cnt", int'(cycle_cnt), 2);
        step = 1'b0; tick(1); step = 1'b1; tick(2);
        chk("step3_cnt", int'(cycle_cnt), 3);
        chk("step3_done", int'(done), 1);
        tick(1);
        step = 1'b0; step_mode = 1'b0;
`else
        // Step inputs have no effect without the step feature
        step_mode = 1'b1; step = 1'b1; limit = 16'd3;
        sb.push_back('{3, 3});
        start = 1'b1; tick(1); start = 1'b0;
        chk("nostep_ce_free", int'(core_ce), 1);
        wait_done();
        chk("nostep_cnt", int'(cycle_cnt), 3);
        step = 1'b0; step_mode = 1'b0;
`endif

        // Reset mid-run at cycle_cnt=17
        limit = 16'd0;
        start = 1'b1; tick(1); start = 1'b0;
        tick(17);
        chk("mid_cnt17", int'(cycle_cnt), 17);
        chk("mid_state_run", int'(state), 2);
        RST = 1'b0; #1;
        chk("mid_rst_core_rst", int'(core_rst), 1);
        chk("mid_rst_core_ce", int'(core_ce), 0);
        chk("mid_rst_cnt", int'(cycle_cnt), 0);
        chk("mid_rst_state", int'(state), 0);
        tick(2);
        RST = 1'b1;
        tick(3);
        chk("rerel_edge3_core_rst", int'(core_rst), 1);
        tick(1);
        chk("rerel_edge4_core_rst", int'(core_rst), 0);
        chk("rerel_edge4_state", int'(state), 1);

        // CNT_W=4 saturation with no limit
        start2 = 1'b1; tick(1); start2 = 1'b0;
        tick(25);
        chk("sat_cnt", int'(cnt2), 15);
        chk("sat_state", int'(state2), 2);
        chk("sat_ce", int'(core_ce2), 1);
        halt2 = 1'b1; tick(1); halt2 = 1'b0;
        chk("sat_halt_done", int'(done2), 1);
        chk("sat_halt_cnt", int'(cnt2), 15);

        tick(2);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
